ws2801_driver: RTL and testbench
================================

# ws2801_driver

Synthesizable serial transmitter for WS2801 LED strips. It accepts a frame of NUM_LEDS 24-bit RGB pixels over a valid/ready stream and shifts them out MSB-first on a generated clock/data pair (cko/sdo). It then holds cko low for the latch interval so the strip loads its registers. It sits between the frame-buffer/pixel pipeline and the strip's first device (CKI/SDI).

## Interface
- NUM_LEDS, 5: pixels per frame (≥1).
- CLK_DIV, 2: system cycles per cko half-period (≥1); 50 MHz clk gives 12.5 MHz cko.
- LATCH_CYCLES, 26000: cycles cko is held low after the last bit (≥500 µs plus margin at 50 MHz).
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle pulse; begins a frame when idle.
- pix_data  input  24  pixel {red[7:0], green[7:0], blue[7:0]}.
- pix_valid  input  1  pix_data valid.
- pix_ready  output  1  driver accepts pixel this cycle.
- sdo  output  1  serial data to strip SDI.
- cko  output  1  serial clock to strip CKI.
- busy  output  1  high from start acceptance until frame_done.
- frame_done  output  1  one-cycle pulse at the end of the latch interval.
- bright  input  8  global brightness; present only with WS2801_BRIGHTNESS_EN.

## Operation
- FSM states: IDLE, LOAD, SHIFT, LATCH.
- IDLE: pix_ready=0, busy=0. On start, go to LOAD, clear the pixel counter, and set busy=1. start is ignored in all other states.
- LOAD: pix_ready=1 and cko=0. On pix_valid&pix_ready, capture the pixel into the 24-bit shift register, clear the bit counter, and go to SHIFT.
- While pix_valid is low, LOAD holds with cko low. A stall of ≥500 µs causes the strip to latch a partial frame; avoiding this is the source's responsibility.
- SHIFT: sdo = shift register bit 23. Each bit has a low phase of CLK_DIV cycles (cko=0) followed by a high phase of CLK_DIV cycles (cko=1).
- At the end of the high phase, shift left by one and increment the bit counter.
- After bit 24, drive cko=0 and increment the pixel counter. Go to LOAD if the count < NUM_LEDS, otherwise go to LATCH.
- LATCH: cko=0 and sdo=0. Count LATCH_CYCLES, then pulse frame_done for one cycle, clear busy, and go to IDLE.
- Widths:
  - bit counter: 5 bits.
  - pixel counter: $clog2(NUM_LEDS+1).
  - divider: $clog2(CLK_DIV+1).
  - latch counter: $clog2(LATCH_CYCLES+1).
  - No counter wraps within a legal frame.

## Timing
- All outputs are registered.
- Reset values: sdo=0, cko=0, pix_ready=0, busy=0, frame_done=0, state=IDLE.
- Reset mid-frame forces cko/sdo low immediately. The strip may latch partial data; this is acceptable.
- start accepted at cycle T: busy=1 and pix_ready=1 at T+1.
- Pixel accepted at cycle N:
  - sdo = bit 23 at N+1.
  - cko rises at N+1+CLK_DIV.
  - cko falls at N+1+2·CLK_DIV.
- Pixel duration is 48·CLK_DIV cycles. Back-to-back pixels with pix_valid held high add exactly one LOAD cycle (cko low) between pixels.
- sdo changes only while cko is low; it is stable for the full high phase.
- Last bit's high phase ends at cycle L: LATCH is entered at L+1 and frame_done pulses at L+1+LATCH_CYCLES.
- A start arriving in the same cycle as frame_done is ignored.
- Full frame at CLK_DIV=2, NUM_LEDS=5 with no stalls is 1+5·(96+1)+LATCH_CYCLES cycles from start.

## Configuration
- WS2801_BRIGHTNESS_EN defined:
  - The bright port exists.
  - Each channel is scaled at capture as (ch·(bright+1))>>8 and stored into the shift register.
  - bright=255 is the identity; bright=0 yields 0x000000.
  - Latency is unchanged.
- Undefined: no bright port; pixels are shifted out unmodified.

## Structure
- ws2801_pkg contains:
  - rgb_t (packed struct red/green/blue, 8 bits each).
  - state enum.
  - LATCH_US constant (500).
- Sub-module ws2801_scale: combinational 8×9 multiply per channel, used for brightness. It is instantiated only under WS2801_BRIGHTNESS_EN.

## Test plan
- NUM_LEDS=1, pixel 0xFF00AA, CLK_DIV=2 → 24 cko rising edges, sdo sampled at rising edges = 111111110000000010101010, then cko low for 26000 cycles, then a single frame_done pulse.
- NUM_LEDS=5, all pixels 0xFFF000 with pix_valid always high → 120 cko pulses with a 1-cycle gap between pixels. A chain of five strip models then shows 0xFFF000 in every device after latch.
- pix_valid dropped for 100 cycles mid-frame → cko stays low, no bits are lost, and the received data is still correct.
- start pulsed while busy → ignored; exactly one frame_done and NUM_LEDS·24 cko edges.
- rst_n asserted mid-SHIFT → sdo/cko/busy/pix_ready=0 immediately. The next start produces a clean full frame.
- WS2801_BRIGHTNESS_EN, bright=127, pixel 0xFF8040 → transmitted 0x7F4020; bright=255 → 0xFF8040.

Source files
------------

// File: rtl/ws2801_pkg.sv
// rtl/ws2801_pkg.sv - shared types and constants for the WS2801 strip driver
package ws2801_pkg;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } state_t;

    // Minimum cko-low time in microseconds before the strip latches its data.
    localparam int LATCH_US = 500;

endpackage

// File: rtl/ws2801_if.sv
// rtl/ws2801_if.sv - pixel stream handshake between pixel source and driver
interface ws2801_if;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/ws2801_scale.sv
// rtl/ws2801_scale.sv - per-channel brightness scaling (ch*(bright+1))>>8
module ws2801_scale
    import ws2801_pkg::*;
(
    input  rgb_t       pix_in,
    input  logic [7:0] bright,
    output rgb_t       pix_out
);

    logic [8:0] gain;

    // bright+1 keeps 255 an exact identity and 0 a hard black.
    assign gain = {1'b0, bright} + 9'd1;

    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [8:0] k);
        logic [15:0] prod;
        prod = 16'(ch) * 16'(k);
        return 8'(prod >> 8);
    endfunction

    assign pix_out.red   = scale_ch(pix_in.red,   gain);
    assign pix_out.green = scale_ch(pix_in.green, gain);
    assign pix_out.blue  = scale_ch(pix_in.blue,  gain);

endmodule

// File: rtl/ws2801_driver.sv
// rtl/ws2801_driver.sv - WS2801 serial frame transmitter; WS2801_BRIGHTNESS_EN adds global brightness
module ws2801_driver
    import ws2801_pkg::*;
#(
    parameter int NUM_LEDS     = 5,
    parameter int CLK_DIV      = 2,
    parameter int LATCH_CYCLES = 26000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    ws2801_if.slave    pix,
`ifdef WS2801_BRIGHTNESS_EN
    input  logic [7:0] bright,
`endif
    output logic       sdo,
    output logic       cko,
    output logic       busy,
    output logic       frame_done
);

    localparam int PIX_W = $clog2(NUM_LEDS + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int LAT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_LEDS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

    state_t           state;
    logic [23:0]      shreg;
    logic [4:0]       bit_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [LAT_W-1:0] lat_cnt;
    rgb_t             captured;

`ifdef WS2801_BRIGHTNESS_EN
    ws2801_scale u_scale (
        .pix_in  (rgb_t'(pix.pix_data)),
        .bright  (bright),
        .pix_out (captured)
    );
`else
    assign captured = rgb_t'(pix.pix_data);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            pix_cnt       <= '0;
            div_cnt       <= '0;
            lat_cnt       <= '0;
            sdo           <= 1'b0;
            cko           <= 1'b0;
            pix.pix_ready <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the previous frame's done pulse is dropped.
                    if (start && !frame_done) begin
                        state         <= LOAD;
                        pix_cnt       <= '0;
                        busy          <= 1'b1;
                        pix.pix_ready <= 1'b1;
                    end
                end

                LOAD: begin
                    cko <= 1'b0;
                    if (pix.pix_valid && pix.pix_ready) begin
                        shreg         <= captured;
                        sdo           <= captured[23];
                        bit_cnt       <= '0;
                        div_cnt       <= '0;
                        pix.pix_ready <= 1'b0;
                        state         <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!cko) begin
                            cko <= 1'b1;
                        end else begin
                            // End of high phase: next bit is set up while cko is low.
                            cko     <= 1'b0;
                            shreg   <= {shreg[22:0], 1'b0};
                            sdo     <= shreg[22];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 5'd23) begin
                                pix_cnt <= pix_cnt + 1'b1;
                                if (pix_cnt == PIX_LAST) begin
                                    state   <= LATCH;
                                    sdo     <= 1'b0;
                                    lat_cnt <= '0;
                                end else begin
                                    state         <= LOAD;
                                    pix.pix_ready <= 1'b1;
                                end
                            end
                        end
                    end
                end

                LATCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2801_driver.sv
// tb/tb_ws2801_driver.sv - scoreboard bench with strip-chain model for ws2801_driver
module tb_ws2801_driver;
    import ws2801_pkg::*;

    localparam int NUM_LEDS     = 5;
    localparam int CLK_DIV      = 2;
    localparam int LATCH_CYCLES = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sdo, cko, busy, frame_done;
`ifdef WS2801_BRIGHTNESS_EN
    logic [7:0] bright = 8'd255;
`endif

    ws2801_if pix_if ();

    always #5 clk = ~clk;

    ws2801_driver #(
        .NUM_LEDS     (NUM_LEDS),
        .CLK_DIV      (CLK_DIV),
        .LATCH_CYCLES (LATCH_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pix        (pix_if),
`ifdef WS2801_BRIGHTNESS_EN
        .bright     (bright),
`endif
        .sdo        (sdo),
        .cko        (cko),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: what the strip must receive for a given source pixel.
    function automatic logic [23:0] model_pix(input logic [23:0] p);
`ifdef WS2801_BRIGHTNESS_EN
        int k;
        logic [23:0] r;
        k = int'(bright) + 1;
        for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'((int'(p[c*8 +: 8]) * k) / 256);
        return r;
`else
        return p;
`endif
    endfunction

    bit          exp_bits[$];
    logic [23:0] sent_q[$];
    logic [23:0] rx_q[$];
    logic [23:0] rx_word = '0;
    int          bit_idx = 0;
    logic        cko_q = 1'b0;
    logic        held = 1'b0;
    int          fall_cyc = 0;
    int          acc_cyc = 0;
    int          done_cnt = 0;

    // Monitor: strip chain model clocking sdo on cko rising edges.
    always @(negedge clk) begin
        bit b;
        if (!rst_n) begin
            exp_bits.delete();
            sent_q.delete();
            rx_q.delete();
            bit_idx = 0;
            cko_q = 1'b0;
        end else begin
            if (cko && !cko_q) begin
                chk("cko_rise_expected", 32'(exp_bits.size() > 0), 32'd1);
                if (exp_bits.size() > 0) begin
                    b = exp_bits.pop_front();
                    chk("sdo_bit", 32'(sdo), 32'(b));
                    if (bit_idx == 0) chk("cko_rise_latency", 32'(cyc - acc_cyc), 32'(CLK_DIV + 1));
                end
                rx_word = {rx_word[22:0], sdo};
                held = sdo;
                bit_idx++;
                if (bit_idx == 24) begin
                    rx_q.push_back(rx_word);
                    bit_idx = 0;
                end
            end else if (cko) begin
                chk("sdo_stable_high", 32'(sdo), 32'(held));
            end
            if (!cko && cko_q) fall_cyc = cyc;
            if (frame_done) begin
                done_cnt++;
                chk("latch_low_cycles", 32'(cyc - fall_cyc), 32'(LATCH_CYCLES));
                chk("devices_loaded", 32'(rx_q.size()), 32'(NUM_LEDS));
                chk("pixels_accepted", 32'(sent_q.size()), 32'(NUM_LEDS));
                for (int i = 0; i < NUM_LEDS; i++)
                    if (i < rx_q.size() && i < sent_q.size())
                        chk("device_pixel", 32'(rx_q[i]), 32'(sent_q[i]));
                chk("bits_left", 32'(exp_bits.size()), 32'd0);
                rx_q.delete();
                sent_q.delete();
            end
            cko_q = cko;
        end
    end

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic feed_pixel(input logic [23:0] p);
        int n;
        logic [23:0] e;
        n = 0;
        pix_if.pix_data  = p;
        pix_if.pix_valid = 1'b1;
        @(negedge clk);
        while (!pix_if.pix_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!pix_if.pix_ready) begin
            chk("pix_ready_wait", 32'(pix_if.pix_ready), 32'd1);
        end else begin
            e = model_pix(p);
            sent_q.push_back(e);
            for (int b = 23; b >= 0; b--) exp_bits.push_back(e[b]);
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0 random back-to-back, 1 all 0xFFF000, 2 100-cycle stall, 3 random gaps + start while busy, 4 all 0xFF8040
    task automatic run_frame(input int mode);
        int t_start, n, d0;
        logic [23:0] p;
        d0 = done_cnt;
        pix_if.pix_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t_start = cyc;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_after_start", 32'(pix_if.pix_ready), 32'd1);
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode)
                1:       p = 24'hFFF000;
                4:       p = 24'hFF8040;
                default: p = 24'($urandom);
            endcase
            if (mode == 2 && i == 2) begin
                pix_if.pix_valid = 1'b0;
                repeat (100) @(posedge clk);
                #1;
            end
            if (mode == 3) begin
                pix_if.pix_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                if (i == 2) begin
                    start = 1'b1;
                    @(posedge clk);
                    #1 start = 1'b0;
                end
            end
            feed_pixel(p);
        end
        pix_if.pix_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!frame_done && n < LATCH_CYCLES + 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_seen", 32'(frame_done), 32'd1);
        if (mode == 0 || mode == 1 || mode == 4)
            chk("frame_cycles", 32'(cyc - t_start), 32'(NUM_LEDS * (48 * CLK_DIV + 1) + LATCH_CYCLES));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_at_done_ignored", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("one_frame_done", 32'(done_cnt - d0), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(pix_if.pix_ready), 32'd0);
    endtask

    initial begin
        pix_if.pix_data  = '0;
        pix_if.pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sdo", 32'(sdo), 32'd0);
        chk("rst_cko", 32'(cko), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(pix_if.pix_ready), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_frame(1);
        run_frame(0);
        run_frame(2);
        run_frame(3);

        // Reset in the middle of a pixel's shift.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        feed_pixel(24'($urandom) | 24'h800000);
        pix_if.pix_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cko", 32'(cko), 32'd0);
        chk("midrst_sdo", 32'(sdo), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(pix_if.pix_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(0);

        run_frame(4);
`ifdef WS2801_BRIGHTNESS_EN
        bright = 8'd127;
        run_frame(4);
        bright = 8'd0;
        run_frame(0);
        bright = 8'($urandom);
        run_frame(0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
